uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the team's uart_tx.
- Accepts an asynchronous serial line, 8N1-style by default (start bit 0, PAYLOAD_SIZE data bits LSB first, one stop bit 1).
- Oversamples each bit and samples at bit centre.
- Presents each received word on a parallel port with a valid/ack handshake, plus error flags.
- State encodings come from the shared uart_states.vh defines: RESET, IDLE, START_BIT, DATA_BIT, STOP_BIT.

Parameters:
- PAYLOAD_SIZE, 8: data bits per frame (>=1).
- OVERSAMPLE, 16: enable ticks per bit period. Must be even and >=4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  oversample tick; state/counters advance only on cycles with enable=1.
- in  input  1  asynchronous serial line, idle high.
- ack  input  1  consumer acknowledges the word on out; clears valid.
- out  output  PAYLOAD_SIZE  last correctly framed word; holds until the next good frame.
- valid  output  1  level; a word is pending on out.
- done  output  1  one-cycle pulse when a good frame is written to out.
- busy  output  1  high in START_BIT, DATA_BIT and STOP_BIT.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  sticky; set when a good frame lands while valid=1 and ack=0. Cleared by reset or by ack.

Behaviour:
- **Reset** (reset=1 at a clk edge): state=IDLE, and all of the following are 0: out, valid, done, busy, frame_err, overrun, and the internal counters. The synchronizer is preset to 1. Reset takes priority over every other event, including mid-frame: the partial frame is discarded and no done or frame_err is produced.
- **Synchronizer:** in passes through 2 flip-flops (rx_s) before any use. Latency is 2 clk.
- **Counters:**
  - tick_cnt: width $clog2(OVERSAMPLE); increments on enable, wraps to 0 at OVERSAMPLE-1.
  - bit_cnt: width $clog2(PAYLOAD_SIZE+1).
- **IDLE:** on enable with rx_s=0 and armed=1, go to START_BIT with tick_cnt=0. The armed flag is set whenever rx_s=1 is seen on a tick in IDLE. It is cleared after a frame_err, so a held-low break is not re-detected as a new start.
- **START_BIT:**
  - On the enable where tick_cnt=OVERSAMPLE/2-1 (the bit midpoint): if rx_s=0, go to DATA_BIT with tick_cnt=0 and bit_cnt=0.
  - If rx_s=1, treat it as a glitch and return to IDLE silently.
- **DATA_BIT:**
  - On the enable where tick_cnt=OVERSAMPLE-1: shift rx_s into the MSB of the shift register (right shift, so the first bit ends in the LSB) and increment bit_cnt.
  - After PAYLOAD_SIZE samples, go to STOP_BIT with tick_cnt=0.
- **STOP_BIT:** on the enable where tick_cnt=OVERSAMPLE-1, sample rx_s, then go to IDLE.
  - rx_s=1: out<=shift register, valid<=1, done pulses for 1 cycle. If valid=1 and ack=0 in that cycle, overrun<=1 and out is overwritten with the new word.
  - rx_s=0: frame_err pulses for 1 cycle; out and valid are unchanged; armed<=0.
- **Handshake:**
  - ack=1 clears valid and overrun on the next edge.
  - If ack and a new good frame occur in the same cycle, the new frame wins: valid stays 1, and overrun is not set.
- **busy** is registered and follows the next state; it is 0 in IDLE.
- **enable=0:** the FSM and counters freeze. The synchronizer and the ack/valid logic still run every clk.
- **Latency** (enable tied high, OVERSAMPLE=16, PAYLOAD_SIZE=8): taking the cycle of the falling edge of in as 0, done is high in cycle 155 (2 sync + 1 detect + 8 + 16*9 samples).

Test Plan:
- Good frame: enable=1, OVERSAMPLE=16, 16 clk per bit, frame 0, LSB-first 0xA5, then 1 -> done high exactly at cycle 155; out=0xA5; valid=1; frame_err=0; busy=0 from cycle 155 onward.
- Start glitch: in low for 4 clk then high -> no state beyond START_BIT; done=0, busy returns to 0, out unchanged.
- Framing error: frame of 0x3C with stop bit 0, held low for 40 further clk, then line high, then a good 0x81 frame -> frame_err pulses once; out and valid keep their prior values; no false start during the low hold; 0x81 is then received with done.
- Overrun: two back-to-back good frames 0x11, 0x22 with ack=0 -> out=0x22, valid=1, overrun=1. One cycle of ack -> valid=0, overrun=0.
- Reset mid-frame: assert reset during DATA_BIT bit 3 of 0x55 -> next cycle state IDLE, busy=0, no done/frame_err. A following 0x0F frame is received correctly.
- Tick gating: enable=1 one cycle in 4, 64 clk per bit, frame 0xF0 -> out=0xF0 and done pulses exactly once.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, start/data/stop FSM sampled at
// bit centre, parallel word out with a valid/ack handshake and framing/overrun flags.
module uart_rx #(
    parameter int PAYLOAD_SIZE = 8,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in,
    input  logic                    ack,
    output logic [PAYLOAD_SIZE-1:0] out,
    output logic                    valid,
    output logic                    done,
    output logic                    busy,
    output logic                    frame_err,
    output logic                    overrun,
    output logic [2:0]              dbg_state
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(PAYLOAD_SIZE + 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAYLOAD_SIZE - 1);

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        IDLE      = 3'd1,
        START_BIT = 3'd2,
        DATA_BIT  = 3'd3,
        STOP_BIT  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [PAYLOAD_SIZE-1:0] shift_q, shift_d;
    logic [PAYLOAD_SIZE-1:0] out_q, out_d;
    logic [1:0]              sync_q;
    logic                    armed_q, armed_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    done_q, frame_err_q, busy_q;
    logic                    good, bad, rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        armed_d = armed_q;
        good    = 1'b0;
        bad     = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    tick_d = '0;
                    // armed blocks a held-low break from looking like a fresh start bit
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = START_BIT;
                    end
                end
                START_BIT: begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? IDLE : DATA_BIT;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                DATA_BIT: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        shift_d = shift_q >> 1;
                        shift_d[PAYLOAD_SIZE-1] = rx_s;
                        bit_d = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP_BIT;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                STOP_BIT: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        if (rx_s) begin
                            good = 1'b1;
                        end else begin
                            bad     = 1'b1;
                            armed_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // Handshake: valid rises with a good frame and drops on the edge after ack=1;
    // a good frame arriving in the same cycle as ack wins and keeps valid high.
    always_comb begin
        out_d     = good ? shift_q : out_q;
        valid_d   = good ? 1'b1 : (ack ? 1'b0 : valid_q);
        overrun_d = ack ? 1'b0 : ((good && valid_q) ? 1'b1 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], in};
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            done_q      <= good;
            frame_err_q <= bad;
            busy_q      <= (state_d == START_BIT) || (state_d == DATA_BIT) || (state_d == STOP_BIT);
        end
    end

    assign out       = out_q;
    assign valid     = valid_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table of whole frames plus hand-written
// sequences for latency, glitch, break, overrun, mid-frame reset and tick gating.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       rx_line = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] dout;
    logic       valid, done, busy, frame_err, overrun;
    logic [2:0] dbg_state;

    uart_rx #(.PAYLOAD_SIZE(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in(rx_line), .ack(ack),
        .out(dout), .valid(valid), .done(done), .busy(busy),
        .frame_err(frame_err), .overrun(overrun), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int          ntests = 0;
    int          nfail = 0;
    logic        gate = 1'b0;
    logic [7:0]  exp_q[$];
    int          done_cnt = 0, ferr_cnt = 0, busy_cnt = 0, data_cnt = 0;
    int unsigned done_edge = 0, fall_edge = 0;
    logic        busy_at_done = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack_after;
        logic [7:0] exp_out;
        logic       exp_valid;
        logic       exp_ovr;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // one clock; outputs sampled 1ns after the edge, scoreboard fed on done
    task automatic step();
        @(posedge clk);
        #1;
        if (done) begin
            done_cnt++;
            done_edge = edge_cnt;
            busy_at_done = busy;
            if (exp_q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL sb_spurious_done: got out=0x%0h, required no done", dout);
            end else begin
                check("sb_word", {24'd0, dout}, {24'd0, exp_q.pop_front()});
            end
        end
        if (frame_err) ferr_cnt++;
        if (busy) busy_cnt++;
        if (dbg_state == ST_DATA) data_cnt++;
        enable = gate ? ((edge_cnt % 4) == 0) : 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int cpb);
        if (stop) exp_q.push_back(data);
        rx_line = 1'b0;
        fall_edge = edge_cnt;
        repeat (cpb) step();
        for (int i = 0; i < 8; i++) begin
            rx_line = data[i];
            repeat (cpb) step();
        end
        rx_line = stop;
        repeat (cpb) step();
        rx_line = 1'b1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
    endtask

    initial begin
        int d0, f0, b0, t0;
        logic [7:0] pat;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0};

        repeat (3) step();
        reset = 1'b0;
        check("rst_out", {24'd0, dout}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        repeat (20) step();

        // latency: done 155 clocks after the falling edge
        d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        send_frame(8'hA5, 1'b1, CPB);
        repeat (10) step();
        check("lat_done_cnt", done_cnt - d0, 32'd1);
        check("lat_cycle", done_edge - fall_edge, 32'd155);
        check("lat_out", {24'd0, dout}, 32'hA5);
        check("lat_valid", {31'd0, valid}, 32'd1);
        check("lat_ferr", ferr_cnt - f0, 32'd0);
        check("lat_busy_at_done", {31'd0, busy_at_done}, 32'd0);
        check("lat_busy_seen", (busy_cnt - b0) > 0, 32'd1);
        do_ack();

        for (int k = 0; k < 6; k++) begin
            d0 = done_cnt; f0 = ferr_cnt;
            send_frame(vecs[k].data, vecs[k].stop, CPB);
            repeat (20) step();
            check($sformatf("vec%0d_out", k), {24'd0, dout}, {24'd0, vecs[k].exp_out});
            check($sformatf("vec%0d_valid", k), {31'd0, valid}, {31'd0, vecs[k].exp_valid});
            check($sformatf("vec%0d_ovr", k), {31'd0, overrun}, {31'd0, vecs[k].exp_ovr});
            check($sformatf("vec%0d_done", k), done_cnt - d0, {31'd0, vecs[k].stop});
            check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, {31'd0, !vecs[k].stop});
            if (vecs[k].ack_after) begin
                do_ack();
                check($sformatf("vec%0d_ack_valid", k), {31'd0, valid}, 32'd0);
                check($sformatf("vec%0d_ack_ovr", k), {31'd0, overrun}, 32'd0);
            end
        end

        // start glitch: 4 clocks low then back high
        d0 = done_cnt; b0 = busy_cnt; t0 = data_cnt;
        rx_line = 1'b0;
        repeat (4) step();
        rx_line = 1'b1;
        repeat (30) step();
        check("glitch_busy_cycles", busy_cnt - b0, 32'd8);
        check("glitch_no_data", data_cnt - t0, 32'd0);
        check("glitch_done", done_cnt - d0, 32'd0);
        check("glitch_busy_now", {31'd0, busy}, 32'd0);
        check("glitch_out", {24'd0, dout}, 32'h81);

        // framing error followed by a 40-clock break
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, CPB);
        rx_line = 1'b0;
        b0 = busy_cnt;
        repeat (40) step();
        check("brk_no_restart", busy_cnt - b0, 32'd0);
        check("brk_ferr_once", ferr_cnt - f0, 32'd1);
        check("brk_done", done_cnt - d0, 32'd0);
        check("brk_out_kept", {24'd0, dout}, 32'h81);
        check("brk_valid_kept", {31'd0, valid}, 32'd0);
        rx_line = 1'b1;
        repeat (32) step();
        d0 = done_cnt;
        send_frame(8'h81, 1'b1, CPB);
        repeat (20) step();
        check("brk_next_done", done_cnt - d0, 32'd1);
        check("brk_next_valid", {31'd0, valid}, 32'd1);
        do_ack();

        // overrun on back-to-back frames
        send_frame(8'h11, 1'b1, CPB);
        send_frame(8'h22, 1'b1, CPB);
        repeat (20) step();
        check("ovr_out", {24'd0, dout}, 32'h22);
        check("ovr_valid", {31'd0, valid}, 32'd1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        do_ack();
        check("ovr_ack_valid", {31'd0, valid}, 32'd0);
        check("ovr_ack_flag", {31'd0, overrun}, 32'd0);

        // ack landing on the same edge as a new good frame
        send_frame(8'h33, 1'b1, CPB);
        repeat (20) step();
        fork
            send_frame(8'h44, 1'b1, CPB);
            begin
                repeat (154) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
        join
        repeat (20) step();
        check("same_out", {24'd0, dout}, 32'h44);
        check("same_valid", {31'd0, valid}, 32'd1);
        check("same_ovr", {31'd0, overrun}, 32'd0);
        do_ack();

        // reset in the middle of data bit 3 of 0x55
        d0 = done_cnt; f0 = ferr_cnt;
        pat = 8'h55;
        rx_line = 1'b0;
        repeat (CPB) step();
        for (int i = 0; i < 3; i++) begin
            rx_line = pat[i];
            repeat (CPB) step();
        end
        rx_line = pat[3];
        repeat (CPB / 2) step();
        check("mid_state_data", {29'd0, dbg_state}, {29'd0, ST_DATA});
        reset = 1'b1;
        rx_line = 1'b1;
        step();
        reset = 1'b0;
        check("mid_state_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_out_cleared", {24'd0, dout}, 32'd0);
        repeat (200) step();
        check("mid_no_done", done_cnt - d0, 32'd0);
        check("mid_no_ferr", ferr_cnt - f0, 32'd0);
        d0 = done_cnt;
        send_frame(8'h0F, 1'b1, CPB);
        repeat (20) step();
        check("mid_next_out", {24'd0, dout}, 32'h0F);
        check("mid_next_done", done_cnt - d0, 32'd1);
        do_ack();

        // enable one clock in four, 64 clocks per bit
        gate = 1'b1;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hF0, 1'b1, 64);
        repeat (100) step();
        check("gate_out", {24'd0, dout}, 32'hF0);
        check("gate_done_once", done_cnt - d0, 32'd1);
        check("gate_ferr", ferr_cnt - f0, 32'd0);
        gate = 1'b0;
        repeat (4) step();

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
